// File: rtl/riscv_mtimer_mc.sv
// riscv_mtimer_mc: RISC-V machine timer with prescaler and per-hart mtimecmp.
// Avalon-MM slave with single-cycle writes and registered reads. A
// lo-then-hi read of mtime is made atomic through a shadow register that
// latches mtime[63:32] whenever mtime_lo is read.
module riscv_mtimer_mc #(
  parameter int NUM_HARTS   = 1,
  parameter int PRESCALE_W  = 16,
  parameter bit CTRL_EN_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           avalon_address,
  input  logic [31:0]          avalon_writedata,
  input  logic                 avalon_write,
  input  logic                 avalon_read,
  output logic [31:0]          avalon_readdata,
  output logic [NUM_HARTS-1:0] irq
);

  logic [63:0]           mtime_q, mtime_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [63:0]           cmp_q [NUM_HARTS];
  logic [63:0]           cmp_d [NUM_HARTS];
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_HARTS-1:0]  irq_q, irq_d;

  logic                  wr_mlo, wr_mhi, wr_ctrl, wr_pre;
  logic                  tick;
  logic [31:0]           rd_word;

  assign wr_mlo  = avalon_write && (avalon_address == 5'd0);
  assign wr_mhi  = avalon_write && (avalon_address == 5'd1);
  assign wr_ctrl = avalon_write && (avalon_address == 5'd2);
  assign wr_pre  = avalon_write && (avalon_address == 5'd3);

  // Prescaler terminal count; only meaningful while counting is enabled.
  assign tick = en_q && (pcnt_q == prescale_q);

  // Control, prescaler and mtime next-state; a bus write to mtime wins over a tick.
  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    mtime_d    = mtime_q;
    if (wr_ctrl) en_d = avalon_writedata[0];
    if (wr_pre) begin
      prescale_d = avalon_writedata[PRESCALE_W-1:0];
      pcnt_d     = '0;
    end else if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    end
    if (wr_mlo)      mtime_d = {mtime_q[63:32], avalon_writedata};
    else if (wr_mhi) mtime_d = {avalon_writedata, mtime_q[31:0]};
    else if (tick)   mtime_d = mtime_q + 64'd1;
  end

  // Per-hart compare registers (half-word writes) and compare-based irq.
  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      cmp_d[i] = cmp_q[i];
      if (avalon_write && (avalon_address == 5'(4 + 2 * i)))
        cmp_d[i] = {cmp_q[i][63:32], avalon_writedata};
      if (avalon_write && (avalon_address == 5'(5 + 2 * i)))
        cmp_d[i] = {avalon_writedata, cmp_q[i][31:0]};
      irq_d[i] = en_q && (mtime_q >= cmp_q[i]);
    end
  end

  // Read mux; unmapped addresses return 0, idle cycles drive readdata to 0.
  always_comb begin
    rd_word = 32'd0;
    case (avalon_address)
      5'd0:    rd_word = mtime_q[31:0];
      5'd1:    rd_word = shadow_q;
      5'd2:    rd_word = {31'd0, en_q};
      5'd3:    rd_word = 32'(prescale_q);
      default: begin
        for (int i = 0; i < NUM_HARTS; i++) begin
          if (avalon_address == 5'(4 + 2 * i)) rd_word = cmp_q[i][31:0];
          if (avalon_address == 5'(5 + 2 * i)) rd_word = cmp_q[i][63:32];
        end
      end
    endcase
    rdata_d  = avalon_read ? rd_word : 32'd0;
    shadow_d = (avalon_read && (avalon_address == 5'd0)) ? mtime_q[63:32] : shadow_q;
  end

  // State registers; reset overrides any bus access in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q    <= '0;
      shadow_q   <= '0;
      en_q       <= CTRL_EN_RST;
      prescale_q <= '0;
      pcnt_q     <= '0;
      rdata_q    <= '0;
      irq_q      <= '0;
      for (int i = 0; i < NUM_HARTS; i++) cmp_q[i] <= '1;
    end else begin
      mtime_q    <= mtime_d;
      shadow_q   <= shadow_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < NUM_HARTS; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  assign avalon_readdata = rdata_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_riscv_mtimer_mc.sv
// Directed testbench for riscv_mtimer_mc with two harts.
module tb_riscv_mtimer_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  avalon_address;
  logic [31:0] avalon_writedata;
  logic        avalon_write;
  logic        avalon_read;
  logic [31:0] avalon_readdata;
  logic [1:0]  irq;

  int nvec  = 0;
  int nfail = 0;

  riscv_mtimer_mc #(.NUM_HARTS(2), .PRESCALE_W(16), .CTRL_EN_RST(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .avalon_address   (avalon_address),
    .avalon_writedata (avalon_writedata),
    .avalon_write     (avalon_write),
    .avalon_read      (avalon_read),
    .avalon_readdata  (avalon_readdata),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avalon_address   = a;
    avalon_writedata = d;
    avalon_write     = 1'b1;
    cyc();
    avalon_write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    avalon_address = a;
    avalon_read    = 1'b1;
    cyc();
    d              = avalon_readdata;
    avalon_read    = 1'b0;
  endtask

  logic [31:0] v, m0, m1, v1;

  initial begin
    reset = 1'b1; avalon_address = '0; avalon_writedata = '0;
    avalon_write = 1'b0; avalon_read = 1'b0;
    cyc(); cyc();
    check("rst_readdata", avalon_readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Free-running count at prescale 0
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("irq_idle", 32'(irq), 32'd0);
    end
    rd(5'd0, v);  check("mtime_10", v, 32'd10);
    cyc();        check("rdata_idle_zero", avalon_readdata, 32'd0);
    rd(5'd2, v);  check("ctrl_rst", v, 32'd1);
    rd(5'd3, v);  check("prescale_rst", v, 32'd0);
    wr(5'd8, 32'h1234_5678);
    rd(5'd8, v);  check("unmapped_rd", v, 32'd0);
    rd(5'd6, v);  check("cmp1_lo_rst", v, 32'hFFFF_FFFF);
    rd(5'd5, v);  check("cmp0_hi_rst", v, 32'hFFFF_FFFF);

    // Prescale 3: one tick every 4 cycles, write restarts the phase
    wr(5'd3, 32'd3);
    rd(5'd0, m0);
    repeat (11) cyc();
    rd(5'd0, v);  check("presc_12cyc", v, m0 + 32'd3);
    wr(5'd3, 32'd3);
    rd(5'd0, m1); check("presc_hold", m1, m0 + 32'd3);
    cyc();
    rd(5'd0, v);  check("presc_restart", v, m1);
    cyc();
    rd(5'd0, v);  check("presc_tick", v, m1 + 32'd1);

    // Atomic lo/hi read across the 32-bit carry
    wr(5'd3, 32'd0);
    wr(5'd0, 32'hFFFF_FFFE);
    wr(5'd1, 32'd0);
    rd(5'd0, v);  check("wrap_lo_a", v, 32'hFFFF_FFFE);
    rd(5'd1, v);  check("wrap_hi_a", v, 32'd0);
    rd(5'd0, v);  check("wrap_lo_b", v, 32'd0);
    rd(5'd1, v);  check("wrap_hi_b", v, 32'd1);

    // Compare on hart 1
    wr(5'd2, 32'd0);
    wr(5'd0, 32'd100);
    wr(5'd1, 32'd0);
    wr(5'd7, 32'd0);
    wr(5'd6, 32'd105);
    rd(5'd6, v);  check("cmp1_lo", v, 32'd105);
    rd(5'd7, v);  check("cmp1_hi", v, 32'd0);
    rd(5'd0, v);  check("mtime_frozen_100", v, 32'd100);
    check("irq_pre", 32'(irq), 32'd0);
    wr(5'd2, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("irq_before_match", 32'(irq), 32'd0);
    end
    cyc();        check("irq_rise", 32'(irq), 32'd2);
    cyc();        check("irq_hold", 32'(irq), 32'd2);
    wr(5'd7, 32'd1);
    check("irq_lag_raise", 32'(irq), 32'd2);
    cyc();        check("irq_drop_raise", 32'(irq), 32'd0);

    // Enable gating
    wr(5'd7, 32'd0);
    cyc();        check("irq_rearm", 32'(irq), 32'd2);
    wr(5'd2, 32'd0);
    check("irq_lag_dis", 32'(irq), 32'd2);
    cyc();        check("irq_drop_dis", 32'(irq), 32'd0);
    rd(5'd0, v1);
    repeat (3) cyc();
    rd(5'd0, v);  check("mtime_held", v, v1);
    wr(5'd2, 32'd1);
    rd(5'd0, v);  check("resume_first", v, v1);
    repeat (3) cyc();
    rd(5'd0, v);  check("resume_count", v, v1 + 32'd4);

    // Reset during a bus write
    wr(5'd3, 32'd7);
    wr(5'd2, 32'd0);
    avalon_address = 5'd2; avalon_writedata = 32'd0; avalon_write = 1'b1;
    reset = 1'b1;
    cyc();
    check("rst2_readdata", avalon_readdata, 32'd0);
    check("rst2_irq", 32'(irq), 32'd0);
    reset = 1'b0; avalon_write = 1'b0;
    rd(5'd0, v);  check("rst2_mtime", v, 32'd0);
    rd(5'd1, v);  check("rst2_shadow", v, 32'd0);
    rd(5'd2, v);  check("rst2_ctrl", v, 32'd1);
    rd(5'd3, v);  check("rst2_prescale", v, 32'd0);
    rd(5'd4, v);  check("rst2_cmp0_lo", v, 32'hFFFF_FFFF);
    rd(5'd7, v);  check("rst2_cmp1_hi", v, 32'hFFFF_FFFF);
    check("rst2_irq_after", 32'(irq), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/riscv_mtimer_mc.md
RISCV_MTIMER_MC -- requirements
Module: riscv_mtimer_mc

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1: number of mtimecmp channels and irq outputs, legal range 1..8.
REQ-002 SHALL have parameter PRESCALE_W, default 16: width of the prescaler divisor register and counter, legal range 1..32.
REQ-003 SHALL have parameter CTRL_EN_RST, default 1: reset value of the counter-enable bit.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port avalon_address, input, 5 bits: word address.
REQ-007 SHALL have port avalon_writedata, input, 32 bits: write data.
REQ-008 SHALL have port avalon_write, input, 1 bit: write strobe, single cycle, no waitrequest.
REQ-009 SHALL have port avalon_read, input, 1 bit: read strobe.
REQ-010 SHALL have port avalon_readdata, output, 32 bits: read data.
REQ-011 SHALL have port irq, output, NUM_HARTS bits: per-hart machine timer interrupt.

Function
REQ-012 SHALL use this address map: 0 mtime_lo, 1 mtime_hi (shadow), 2 ctrl (bit0 = enable, other bits read 0), 3 prescale, 4+2i mtimecmp[i]_lo, 5+2i mtimecmp[i]_hi, for i in 0..NUM_HARTS-1.
REQ-013 SHALL return avalon_readdata registered, one cycle after the avalon_read cycle; SHALL drive it to 0 in any cycle following a non-read cycle.
REQ-014 SHALL return 0 for reads of unmapped addresses and SHALL ignore writes to them.
REQ-015 SHALL capture mtime[63:32] into a 32-bit shadow register whenever address 0 is read, in the same edge that captures mtime[31:0] into readdata.
REQ-016 SHALL return the shadow register, not live mtime_hi, when address 1 is read, so a lo-then-hi read pair is atomic.
REQ-017 SHALL include a PRESCALE_W-bit prescaler counter that, while enable=1, counts 0..prescale and produces a one-cycle tick on the cycle it equals prescale, then wraps to 0.
REQ-018 SHALL, with prescale=0, tick every cycle; with prescale=N, tick every N+1 cycles.
REQ-019 SHALL increment the 64-bit mtime by 1 on each tick, wrapping from 2^64-1 to 0.
REQ-020 SHALL, while enable=0, hold both the prescaler counter and mtime.
REQ-021 SHALL clear the prescaler counter to 0 in the cycle prescale is written; SHALL take the new divisor from the next cycle.
REQ-022 SHALL, on a write to address 0 or 1, replace only the addressed half of mtime; the other half holds, and no increment occurs that cycle even if a tick coincides.
REQ-023 SHALL, on a write to an mtimecmp half, replace only that half; the other half is unchanged.
REQ-024 SHALL register irq[i] each cycle as enable AND (mtime >= mtimecmp[i]), unsigned 64-bit, using the register values of that cycle, so irq lags register state by one cycle.
REQ-025 SHALL keep irq[i] asserted until software raises mtimecmp[i] above mtime or clears enable.

Reset
REQ-026 SHALL, on reset, set mtime, shadow, prescale, prescaler counter, readdata and irq to 0.
REQ-027 SHALL, on reset, set every mtimecmp[i] to 64'hFFFF_FFFF_FFFF_FFFF, so that no irq follows reset.
REQ-028 SHALL, on reset, set enable to CTRL_EN_RST.
REQ-029 SHALL give reset priority over any simultaneous bus access, discarding that access.

Verification
REQ-030 Reset, prescale=0, wait 10 cycles, read addr 0 -> mtime_lo approximately 10, with exact value matching the cycle count; irq stays 0 throughout.
REQ-031 Write prescale=3, count 12 cycles -> mtime advanced by exactly 3; a prescale write in mid-count restarts the prescaler phase.
REQ-032 Write mtime_lo=FFFF_FFFE and mtime_hi=0, then read addr 0 and addr 1 across the wrap -> a consistent pair (hi 0 with lo FFFF_FFFx, or hi 1 with small lo); never hi from after the wrap paired with lo from before it.
REQ-033 NUM_HARTS=2, write mtimecmp[1]=mtime+5 (hi half first, then lo) -> irq[1] rises exactly one cycle after mtime reaches that value; irq[0] stays 0; irq[1] drops one cycle after mtimecmp[1] is raised.
REQ-034 Clear enable -> mtime frozen and irq drops one cycle later; set enable -> counting resumes from the held value; reset asserted during a write -> all REQ-026..REQ-028 values restored.
